sm4_ck_seq: RTL and testbench
=============================

SM4_CK_SEQ -- requirements
Module: sm4_ck_seq

Interface
REQ-001 Parameter NUM_ROUNDS, default 32, number of round constants in a sequence; legal range 1..32.
REQ-002 Parameter IDX_W, default 5, width of round index ports; SHALL satisfy 2^IDX_W >= NUM_ROUNDS.
REQ-003 Parameter BYTE_STEP, default 7, byte increment of the constant generator.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request to begin a sequence; accepted only while busy=0.
REQ-007 dir  in  1  order select, sampled with accepted start: 0 ascending, 1 descending.
REQ-008 abort  in  1  synchronous cancel of the running sequence.
REQ-009 busy  out  1  high from accepted start until the sequence ends or is aborted.
REQ-010 ck_valid  out  1  ck_out/ck_round/ck_last hold a valid beat.
REQ-011 ck_ready  in  1  consumer accepts the beat when ck_valid&&ck_ready.
REQ-012 ck_out  out  32  round constant CK for ck_round.
REQ-013 ck_round  out  IDX_W  round index of the current beat.
REQ-014 ck_last  out  1  current beat is the final beat of the sequence.
REQ-015 done  out  1  one-cycle pulse after the final beat is accepted.
REQ-016 lk_idx  in  IDX_W  random-access lookup index.
REQ-017 lk_ck  out  32  registered random-access constant for lk_idx.

Function
REQ-018 Constant rule: byte j (j=0 MSB..3 LSB) of CK(i) SHALL equal (BYTE_STEP*(4*i+j)) mod 256, computed arithmetically (no stored table); i.e. CK(0)=32'h00070e15, CK(9)=32'hfc030a11, CK(31)=32'h646b7279.
REQ-019 FSM states IDLE, RUN; IDLE->RUN on start&&!abort; RUN->IDLE on final beat accepted or on abort.
REQ-020 start asserted while busy=1 SHALL be ignored (no restart, no dir change).
REQ-021 Latency: start accepted at edge T -> busy=1 and ck_valid=1 with the first beat registered at edge T (visible after T).
REQ-022 First beat index: 0 if dir=0, NUM_ROUNDS-1 if dir=1; each accepted beat advances index by +1 (dir=0) or -1 (dir=1); no wrap-around.
REQ-023 While ck_valid=1 and ck_ready=0, ck_out, ck_round, ck_last SHALL hold stable; ck_valid SHALL not drop except by abort or reset.
REQ-024 Back-to-back: with ck_ready held 1, one beat per cycle; NUM_ROUNDS beats in NUM_ROUNDS consecutive cycles.
REQ-025 ck_last=1 exactly on beat index NUM_ROUNDS-1 (dir=0) or 0 (dir=1); with NUM_ROUNDS=1 the single beat has ck_last=1.
REQ-026 On acceptance of the ck_last beat: next cycle ck_valid=0, busy=0, done=1 for exactly one cycle; a start in the done cycle is accepted.
REQ-027 abort in RUN: next cycle ck_valid=0, busy=0, done stays 0; abort takes priority over a simultaneous start and over a simultaneous beat acceptance.
REQ-028 abort in IDLE has no effect.
REQ-029 ck_out/ck_round/ck_last SHALL be 0 whenever ck_valid=0.
REQ-030 Lookup port independent of FSM: lk_ck at edge T+1 = CK(lk_idx sampled at T); lk_idx >= NUM_ROUNDS yields 32'h0.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, ck_valid=0, done=0, ck_out=0, ck_round=0, ck_last=0, lk_ck=0.
REQ-032 Reset mid-sequence discards the sequence; after rst_n release the block waits in IDLE for a new start.

Verification
REQ-033 Default params, dir=0, ck_ready=1, start pulse -> 32 consecutive beats ck_round 0..31, first ck_out 32'h00070e15, beat 9 32'hfc030a11, beat 31 32'h646b7279 with ck_last=1, then done=1 one cycle.
REQ-034 dir=1 -> first beat ck_round=31 ck_out=32'h646b7279, last beat ck_round=0 ck_out=32'h00070e15 ck_last=1.
REQ-035 ck_ready toggled pseudo-randomly -> outputs stable during stalls, each index delivered exactly once, in order; start pulses during busy ignored.
REQ-036 abort asserted together with ck_ready at beat 5 -> next cycle ck_valid=0, busy=0, done=0; new start then begins at ck_round 0.
REQ-037 NUM_ROUNDS=1 instance -> single beat ck_round=0 ck_out=32'h00070e15 ck_last=1; lk_idx=1 -> lk_ck=32'h0.
REQ-038 rst_n pulled low mid-sequence and during lookup -> all outputs 0 without clock edge; lk_idx=5 after release -> lk_ck=32'h8c939aa1 one cycle later.

Source files
------------

// File: rtl/sm4_ck_seq.sv
// SM4 key-schedule round-constant sequencer: streams CK(i) beats over a valid/ready
// handshake in ascending or descending order, plus an independent registered lookup port.
module sm4_ck_seq #(
    parameter int NUM_ROUNDS = 32,
    parameter int IDX_W      = 5,
    parameter int BYTE_STEP  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    output logic             busy,
    output logic             ck_valid,
    input  logic             ck_ready,
    output logic [31:0]      ck_out,
    output logic [IDX_W-1:0] ck_round,
    output logic             ck_last,
    output logic             done,
    input  logic [IDX_W-1:0] lk_idx,
    output logic [31:0]      lk_ck
);

    // state | meaning
    // IDLE  | no sequence; waiting for start
    // RUN   | presenting beats until the last one is accepted or abort
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_ROUNDS - 1);

    state_t           state;
    logic             dir_q;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_last;

    // Byte j of CK(i) is BYTE_STEP*(4i+j) mod 256; the cast does the modulo.
    function automatic logic [31:0] ck_of(input logic [IDX_W-1:0] idx);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[8*(3-j) +: 8] = 8'(BYTE_STEP * (4 * int'(idx) + j));
        end
        return r;
    endfunction

    always_comb begin
        first_idx = dir ? TOP_IDX : '0;
        nxt_idx   = dir_q ? ck_round - IDX_W'(1) : ck_round + IDX_W'(1);
        nxt_last  = dir_q ? (nxt_idx == '0) : (nxt_idx == TOP_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_q    <= 1'b0;
            busy     <= 1'b0;
            ck_valid <= 1'b0;
            ck_out   <= '0;
            ck_round <= '0;
            ck_last  <= 1'b0;
            done     <= 1'b0;
            lk_ck    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        ck_valid <= 1'b1;
                        dir_q    <= dir;
                        ck_round <= first_idx;
                        ck_out   <= ck_of(first_idx);
                        ck_last  <= (NUM_ROUNDS == 1);
                    end
                end
                RUN: begin
                    // Abort wins over a same-cycle handshake and suppresses done.
                    if (abort || (ck_ready && ck_last)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ck_valid <= 1'b0;
                        ck_out   <= '0;
                        ck_round <= '0;
                        ck_last  <= 1'b0;
                        done     <= !abort;
                    end else if (ck_ready) begin
                        ck_round <= nxt_idx;
                        ck_out   <= ck_of(nxt_idx);
                        ck_last  <= nxt_last;
                    end
                end
                default: state <= IDLE;
            endcase
            lk_ck <= (int'(lk_idx) < NUM_ROUNDS) ? ck_of(lk_idx) : '0;
        end
    end

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Bench for sm4_ck_seq: beat-count model checked every cycle, plus directed literal checks.
module tb_sm4_ck_seq;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, dir = 1'b0, abort = 1'b0, ck_ready = 1'b0;
    logic [IW-1:0] lk_idx = '0;
    logic          busy, ck_valid, ck_last, done;
    logic [31:0]   ck_out, lk_ck;
    logic [IW-1:0] ck_round;

    logic          start1 = 1'b0, dir1 = 1'b0, abort1 = 1'b0, ck_ready1 = 1'b0;
    logic [0:0]    lk_idx1 = '0;
    logic          busy1, ck_valid1, ck_last1, done1;
    logic [31:0]   ck_out1, lk_ck1;
    logic [0:0]    ck_round1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sm4_ck_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
        .busy(busy), .ck_valid(ck_valid), .ck_ready(ck_ready), .ck_out(ck_out),
        .ck_round(ck_round), .ck_last(ck_last), .done(done),
        .lk_idx(lk_idx), .lk_ck(lk_ck)
    );

    sm4_ck_seq #(.NUM_ROUNDS(1), .IDX_W(1), .BYTE_STEP(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dir(dir1), .abort(abort1),
        .busy(busy1), .ck_valid(ck_valid1), .ck_ready(ck_ready1), .ck_out(ck_out1),
        .ck_round(ck_round1), .ck_last(ck_last1), .done(done1),
        .lk_idx(lk_idx1), .lk_ck(lk_ck1)
    );

    // Constant straight from the byte rule: consecutive byte numbers k = 4i..4i+3.
    function automatic logic [31:0] ck_model(input int i);
        logic [31:0] v;
        v = '0;
        for (int k = 4 * i; k < 4 * i + 4; k++) v = {v[23:0], 8'((7 * k) % 256)};
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sequence is just "how many beats have been accepted so far".
    logic        m_busy, m_dir, m_done;
    int          m_pos;
    logic [31:0] m_lk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_pos = 0; m_lk = '0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start && !abort) begin
                    m_busy = 1'b1; m_dir = dir; m_pos = 0;
                end
            end else if (abort) begin
                m_busy = 1'b0;
            end else if (ck_ready) begin
                if (m_pos == N - 1) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_pos++;
                end
            end
            m_lk = (int'(lk_idx) < N) ? ck_model(int'(lk_idx)) : '0;
        end
    end

    logic        p_hold = 1'b0;
    logic [31:0] p_out;
    logic [IW-1:0] p_round;
    logic        p_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_hold = 1'b0;
        end else begin
            int er;
            er = m_dir ? (N - 1 - m_pos) : m_pos;
            check("busy", busy, m_busy);
            check("ck_valid", ck_valid, m_busy);
            check("done", done, m_done);
            check("ck_round", ck_round, m_busy ? er : 0);
            check("ck_out", ck_out, m_busy ? ck_model(er) : 32'h0);
            check("ck_last", ck_last, m_busy && (m_pos == N - 1));
            check("lk_ck", lk_ck, m_lk);
            if (p_hold) begin
                check("stall_ck_out", ck_out, p_out);
                check("stall_ck_round", ck_round, p_round);
                check("stall_ck_last", ck_last, p_last);
            end
            p_hold  = ck_valid && !ck_ready && !abort;
            p_out   = ck_out;
            p_round = ck_round;
            p_last  = ck_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, beats;
        #2;
        check("rst_busy", busy, 0);
        check("rst_ck_valid", ck_valid, 0);
        check("rst_lk_ck", lk_ck, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Ascending, back-to-back
        dir = 1'b0; ck_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("asc_first_out", ck_out, 32'h00070e15);
        check("asc_first_round", ck_round, 0);
        for (int b = 0; b < N; b++) begin
            if (b == 9) check("asc_beat9", ck_out, 32'hfc030a11);
            if (b == 31) begin
                check("asc_beat31", ck_out, 32'h646b7279);
                check("asc_last31", ck_last, 1);
            end
            tick();
        end
        check("asc_done", done, 1);
        check("asc_busy_end", busy, 0);
        tick();
        check("asc_done_once", done, 0);

        // Descending
        dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; dir = 1'b0;
        check("dsc_first_round", ck_round, 31);
        check("dsc_first_out", ck_out, 32'h646b7279);
        repeat (N - 1) tick();
        check("dsc_last_round", ck_round, 0);
        check("dsc_last_out", ck_out, 32'h00070e15);
        check("dsc_last_flag", ck_last, 1);
        tick();
        check("dsc_done", done, 1);

        // Random backpressure with ignored start pulses while busy
        dir = 1'b0; ck_ready = 1'b0; start = 1'b1;
        tick();
        cnt = 0; beats = 0;
        while (busy && cnt < 400) begin
            ck_ready = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom_range(0, 1));
            lk_idx   = IW'($urandom_range(0, N - 1));
            if (ck_valid && ck_ready) beats++;
            tick();
            cnt++;
        end
        start = 1'b0; dir = 1'b0;
        check("stall_timeout", busy, 0);
        check("stall_beats", beats, N);
        check("stall_done", done, 1);

        // Abort at beat 5, together with ready and a start
        ck_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_at5", ck_round, 5);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_valid", ck_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_round", ck_round, 0);
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Single-round instance
        start1 = 1'b1; ck_ready1 = 1'b0;
        tick();
        start1 = 1'b0;
        check("n1_valid", ck_valid1, 1);
        check("n1_round", ck_round1, 0);
        check("n1_out", ck_out1, 32'h00070e15);
        check("n1_last", ck_last1, 1);
        ck_ready1 = 1'b1; lk_idx1 = 1'b1;
        tick();
        check("n1_end_valid", ck_valid1, 0);
        check("n1_done", done1, 1);
        check("n1_lk_oob", lk_ck1, 0);
        lk_idx1 = 1'b0;
        tick();
        check("n1_lk0", lk_ck1, 32'h00070e15);
        check("n1_done_once", done1, 0);

        // Async reset mid-sequence and mid-lookup
        lk_idx = 5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_rst_lk", lk_ck, 32'h8c939aa1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", ck_valid, 0);
        check("arst_out", ck_out, 0);
        check("arst_round", ck_round, 0);
        check("arst_last", ck_last, 0);
        check("arst_done", done, 0);
        check("arst_lk", lk_ck, 0);
        check("arst_lk1", lk_ck1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_lk", lk_ck, 32'h8c939aa1);
        check("post_rst_busy", busy, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
